// File: rtl/fb_write_sched_pkg.sv
// Shared constants for the BottleFlip frame-buffer write path: buffer geometry,
// colour codes and the scheduler state encoding.
package fb_write_sched_pkg;

  localparam int FB_PX_WIDTH  = 100;
  localparam int FB_PX_HEIGHT = 120;

  localparam logic [2:0] COL_BG     = 3'd0;
  localparam logic [2:0] COL_BOTTLE = 3'd1;
  localparam logic [2:0] COL_LABEL  = 3'd2;
  localparam logic [2:0] COL_TABLE  = 3'd3;
  localparam logic [2:0] COL_EDGE   = 3'd4;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic int blk_addr(input int row, input int col);
    return row * FB_PX_WIDTH + col;
  endfunction

endpackage

// File: rtl/fb_write_sched_rr_arb2.sv
// Two-way round-robin grant; grants are combinational, the last winner is registered.
// Zero latency; a requester that is not granted simply keeps its valid high.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1,
  output logic winner,
  output logic xfer
);

  logic last_grant;

  // On a tie the requester that did not win last time goes next.
  assign ready0 = en & valid0 & (~valid1 | last_grant);
  assign ready1 = en & valid1 & (~valid0 | ~last_grant);
  assign xfer   = ready0 | ready1;
  assign winner = ready1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= ready1;
    end
  end

endmodule

// File: rtl/fb_write_sched.sv
// Pixel-RAM write-port scheduler: round-robin between two requesters plus a full-buffer clear.
// One-cycle handshake-to-write latency; readies drop while clearing or outside the write window.
module fb_write_sched
  import fb_write_sched_pkg::*;
#(
  parameter int PX_WIDTH    = FB_PX_WIDTH,
  parameter int PX_HEIGHT   = FB_PX_HEIGHT,
  parameter int ADDR_W      = 16,
  parameter bit GATE_VBLANK = 1'b1
) (
  input  logic              dclk,
  input  logic              clr,
  input  logic              vblank,
  input  logic              clear_start,
  input  logic [2:0]        clear_code,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [2:0]        req0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [2:0]        req1_data,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              wmem_we,
  output logic [ADDR_W-1:0] wmem_addr,
  output logic [2:0]        wmem_data,
  output logic              busy,
  output logic              clear_done,
  output logic              oob
);

  localparam int unsigned       TOTAL_I = PX_WIDTH * PX_HEIGHT;
  localparam logic [ADDR_W:0]   TOTAL   = (ADDR_W + 1)'(TOTAL_I);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(TOTAL_I - 1);

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [2:0]        code;

  logic              win;
  logic              arb_en;
  logic              winner;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_data;
  logic              in_range;

  assign win = !GATE_VBLANK || vblank;

  // clear_start pre-empts the arbiter in the cycle it is seen; reset also masks grants.
  assign arb_en = !clr && (state == ST_ARB) && win && !clear_start;

  rr_arb2 u_arb (
    .clk    (dclk),
    .rst    (clr),
    .en     (arb_en),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ready0 (req0_ready),
    .ready1 (req1_ready),
    .winner (winner),
    .xfer   (xfer)
  );

  assign sel_addr = winner ? req1_addr : req0_addr;
  assign sel_data = winner ? req1_data : req0_data;
  assign in_range = {1'b0, sel_addr} < TOTAL;
  assign busy     = (state == ST_CLEAR);

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state      <= ST_ARB;
      cnt        <= '0;
      code       <= '0;
      wmem_we    <= 1'b0;
      wmem_addr  <= '0;
      wmem_data  <= '0;
      clear_done <= 1'b0;
      oob        <= 1'b0;
    end else begin
      wmem_we    <= 1'b0;
      clear_done <= 1'b0;
      oob        <= 1'b0;
      if (state == ST_ARB) begin
        if (clear_start) begin
          code  <= clear_code;
          cnt   <= '0;
          state <= ST_CLEAR;
        end else if (xfer) begin
          // Out-of-range requests are consumed but never reach the RAM.
          if (in_range) begin
            wmem_we   <= 1'b1;
            wmem_addr <= sel_addr;
            wmem_data <= sel_data;
          end else begin
            oob <= 1'b1;
          end
        end
      end else if (win) begin
        wmem_we   <= 1'b1;
        wmem_addr <= cnt;
        wmem_data <= code;
        if (cnt == LAST) begin
          clear_done <= 1'b1;
          cnt        <= '0;
          state      <= ST_ARB;
        end else begin
          cnt <= cnt + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched: stimulus pushes expected RAM-port events,
// a negedge monitor pops and compares them as the DUT presents writes/oob pulses.
module tb_fb_write_sched;
  import fb_write_sched_pkg::*;

  localparam int AW    = 16;
  localparam int TOTAL = FB_PX_WIDTH * FB_PX_HEIGHT;

  logic          dclk = 1'b0;
  logic          clr;
  logic          vblank;
  logic          clear_start;
  logic [2:0]    clear_code;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [2:0]    req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          wmem_we;
  logic [AW-1:0] wmem_addr;
  logic [2:0]    wmem_data;
  logic          busy, clear_done, oob;

  fb_write_sched #(
    .PX_WIDTH    (FB_PX_WIDTH),
    .PX_HEIGHT   (FB_PX_HEIGHT),
    .ADDR_W      (AW),
    .GATE_VBLANK (1'b1)
  ) dut (
    .dclk        (dclk),
    .clr         (clr),
    .vblank      (vblank),
    .clear_start (clear_start),
    .clear_code  (clear_code),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_data   (req0_data),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_data   (req1_data),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .wmem_we     (wmem_we),
    .wmem_addr   (wmem_addr),
    .wmem_data   (wmem_data),
    .busy        (busy),
    .clear_done  (clear_done),
    .oob         (oob)
  );

  always #20 dclk = ~dclk;

  int cyc_cnt = 0;
  always @(posedge dclk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit is_oob;
    int addr;
    int data;
    bit done;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  bit   vb_prev = 1'b0;
  int   last_addr = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic exp_t mk(input bit o, input int a, input int d, input bit dn, input int c);
    exp_t e;
    e.is_oob = o;
    e.addr   = a;
    e.data   = d;
    e.done   = dn;
    e.cyc    = c;
    return e;
  endfunction

  task automatic step;
    @(posedge dclk);
    #1;
  endtask

  task automatic smp;
    @(negedge dclk);
  endtask

  // Monitor: every write, oob or clear_done pulse must match the head of the queue.
  always @(negedge dclk) begin
    if (!clr && (wmem_we || oob || clear_done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", int'({wmem_we, oob, clear_done}), 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_kind", int'({oob, wmem_we, clear_done}),
            int'({mon_e.is_oob, !mon_e.is_oob, mon_e.done}));
        if (!mon_e.is_oob) begin
          chk("out_addr", int'(wmem_addr), mon_e.addr);
          chk("out_data", int'(wmem_data), mon_e.data);
        end
        if (mon_e.cyc >= 0) chk("out_cycle", cyc_cnt, mon_e.cyc);
        if (wmem_we) chk("we_in_window", int'(vb_prev), 1);
        last_addr = int'(wmem_addr);
      end
    end
    vb_prev = vblank;
  end

  initial begin
    #(95000 * 40);
    $display("FAIL watchdog cycles=%0d", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  c0;
    bit  got;
    int  busy_cyc;
    int  rdy_cyc;
    bit  hit;

    clr = 1'b1; vblank = 1'b0; clear_start = 1'b0; clear_code = 3'd0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    repeat (3) step;
    chk("rst_outputs", int'({wmem_we, wmem_addr, wmem_data, busy, clear_done, oob,
                             req0_ready, req1_ready}), 0);
    clr = 1'b0;
    vblank = 1'b1;

    // Tie-break: both requesters continuously valid, req0 wins first.
    req0_addr = 16'd5; req0_data = COL_BOTTLE; req0_valid = 1'b1;
    req1_addr = 16'd7; req1_data = COL_LABEL;  req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("tie_grant", int'({req0_ready, req1_ready}), (i % 2 == 0) ? 2 : 1);
      if (i % 2 == 0) exp_q.push_back(mk(1'b0, 5, 1, 1'b0, cyc_cnt + 1));
      else            exp_q.push_back(mk(1'b0, 7, 2, 1'b0, cyc_cnt + 1));
      step;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Vblank gating: nothing granted while the window is closed.
    vblank = 1'b0;
    req0_addr = 16'd10; req0_data = COL_EDGE; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp;
      chk("gate_ready", int'({req0_ready, req1_ready}), 0);
      step;
    end
    vblank = 1'b1;
    smp;
    chk("gate_open_ready", int'(req0_ready), 1);
    exp_q.push_back(mk(1'b0, 10, 4, 1'b0, cyc_cnt + 1));
    step;
    req0_valid = 1'b0;

    // Clear with req1 pending; a second clear_start mid-way must be ignored.
    req1_addr = 16'd20; req1_data = 3'd5; req1_valid = 1'b1;
    clear_start = 1'b1; clear_code = COL_TABLE;
    smp;
    chk("clr_priority", int'({req0_ready, req1_ready}), 0);
    c0 = cyc_cnt;
    for (int i = 0; i < TOTAL; i++)
      exp_q.push_back(mk(1'b0, i, 3, i == TOTAL - 1, c0 + 2 + i));
    step;
    clear_start = 1'b0; clear_code = 3'd7;
    got = 1'b0; busy_cyc = 0; rdy_cyc = -1;
    for (int k = 0; k < TOTAL + 100 && !got; k++) begin
      smp;
      if (req1_ready) begin
        got = 1'b1;
        rdy_cyc = cyc_cnt;
        chk("clr_busy_at_ready", int'(busy), 0);
        exp_q.push_back(mk(1'b0, 20, 5, 1'b0, cyc_cnt + 1));
      end else begin
        if (busy) busy_cyc++;
        step;
        clear_start = (k == 100);
        clear_code  = (k == 100) ? 3'd6 : 3'd7;
      end
    end
    chk("clr_ready_seen", int'(got), 1);
    chk("clr_busy_cycles", busy_cyc, TOTAL);
    chk("clr_ready_cycle", rdy_cyc, c0 + 1 + TOTAL);
    step;
    req1_valid = 1'b0;

    // Out-of-range request is consumed once and still moves the round-robin pointer.
    req0_addr = 16'(TOTAL); req0_data = COL_BOTTLE; req0_valid = 1'b1;
    smp;
    chk("oob_ready", int'(req0_ready), 1);
    exp_q.push_back(mk(1'b1, 0, 0, 1'b0, cyc_cnt + 1));
    step;
    req0_addr = 16'd30; req0_data = COL_LABEL; req0_valid = 1'b1;
    req1_addr = 16'd31; req1_data = COL_TABLE; req1_valid = 1'b1;
    smp;
    chk("oob_next_grant", int'({req0_ready, req1_ready}), 1);
    exp_q.push_back(mk(1'b0, 31, 3, 1'b0, cyc_cnt + 1));
    step;
    req1_valid = 1'b0;
    smp;
    chk("oob_req0_new", int'(req0_ready), 1);
    exp_q.push_back(mk(1'b0, 30, 2, 1'b0, cyc_cnt + 1));
    step;
    req0_valid = 1'b0;

    // Clear with vblank toggling every 100 cycles: sequence must stay contiguous.
    clear_start = 1'b1; clear_code = COL_EDGE;
    smp;
    for (int i = 0; i < TOTAL; i++)
      exp_q.push_back(mk(1'b0, i, 4, i == TOTAL - 1, -1));
    step;
    clear_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30000 && !got; k++) begin
      smp;
      if (clear_done) begin
        got = 1'b1;
      end else begin
        step;
        vblank = (((k + 1) / 100) % 2) == 0;
      end
    end
    step;
    vblank = 1'b1;
    chk("stall_done_seen", int'(got), 1);
    chk("stall_last_addr", last_addr, TOTAL - 1);
    chk("stall_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a clear, right before address 500 would be written.
    clear_start = 1'b1; clear_code = COL_LABEL;
    smp;
    c0 = cyc_cnt;
    for (int i = 0; i < TOTAL; i++)
      exp_q.push_back(mk(1'b0, i, 2, i == TOTAL - 1, c0 + 2 + i));
    step;
    clear_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      smp;
      if (wmem_we && wmem_addr == 16'd499) hit = 1'b1;
      else step;
    end
    chk("midrst_reached", int'(hit), 1);
    #2;
    clr = 1'b1;
    req0_addr = 16'd42; req0_data = COL_LABEL;  req0_valid = 1'b1;
    req1_addr = 16'd43; req1_data = COL_BOTTLE; req1_valid = 1'b1;
    #1;
    chk("midrst_outputs", int'({wmem_we, wmem_addr, wmem_data, busy, clear_done, oob,
                                req0_ready, req1_ready}), 0);
    exp_q.delete();
    smp;
    chk("midrst_ready_masked", int'({req0_ready, req1_ready}), 0);
    step;
    clr = 1'b0;
    smp;
    chk("post_rst_grant", int'({req0_ready, req1_ready}), 2);
    chk("post_rst_busy", int'(busy), 0);
    exp_q.push_back(mk(1'b0, 42, 2, 1'b0, cyc_cnt + 1));
    step;
    req0_valid = 1'b0;
    smp;
    chk("post_rst_req1", int'(req1_ready), 1);
    exp_q.push_back(mk(1'b0, 43, 1, 1'b0, cyc_cnt + 1));
    step;
    req1_valid = 1'b0;

    repeat (3) step;
    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
